reg_writeback_arbiter: RTL
==========================

// Module: reg_writeback_arbiter
// PURPOSE
// Write-side front end of register_bank. Merges two write-back sources (ALU, load return) into the
// single bank write port (i_con_RegWr/i_addr_Rd/i_data_Rd). Loads go through a DEPTH-entry FIFO.
// Bounded-starvation priority and WAW blocking keep register ordering correct. Exports a
// pending-register mask for the hazard unit.
// PARAMETERS
// DEPTH       4   load-return FIFO entries; power of 2, >=2
// STARVE_MAX  3   max consecutive ALU wins while FIFO non-empty before a forced load drain
// PORTS
// i_clk            in   1   clock, rising edge
// i_rst_n          in   1   reset, asynchronous, active-low
// i_alu_valid      in   1   ALU result present
// o_alu_ready      out  1   ALU result accepted this cycle (valid&ready)
// i_alu_rd         in   5   ALU destination register
// i_alu_data       in   32  ALU result
// i_ld_valid       in   1   load return present
// o_ld_ready       out  1   FIFO can accept (= !full)
// i_ld_rd          in   5   load destination register
// i_ld_data        in   32  load data
// o_con_RegWr      out  1   bank write enable (registered)
// o_addr_Rd        out  5   bank write address (registered)
// o_data_Rd        out  32  bank write data (registered)
// o_pending_mask   out  32  bit r set = write to r queued or in output stage; bit 0 always 0
// BEHAVIOUR
// - Reset (async, any cycle incl. mid-op): FIFO flushed (rd/wr ptrs, count =0), starve_cnt=0,
//   o_con_RegWr=0, o_addr_Rd=0, o_data_Rd=0, o_pending_mask=0; queued loads are discarded.
// - FIFO: enq on i_ld_valid&o_ld_ready; o_ld_ready=!full, never depends on same-cycle pop.
//   Ptrs wrap mod DEPTH; count 0..DEPTH. An entry is eligible for pop from the cycle after enq.
// - Per cycle, exactly one select (or none): fifo_ne=count!=0.
//   waw   = fifo_ne & i_alu_rd!=0 & (i_alu_rd matches rd of any valid FIFO entry)
//   force = fifo_ne & starve_cnt==STARVE_MAX
//   o_alu_ready = !waw & !force (combinational).
//   ALU selected if i_alu_valid&o_alu_ready; else FIFO head popped if fifo_ne; else idle.
// - starve_cnt: +1 when ALU selected & fifo_ne; 0 on FIFO pop or when FIFO empty; saturates.
// - Output stage, next posedge after select: o_addr_Rd/o_data_Rd <= selected rd/data;
//   o_con_RegWr <= 1 iff selected & rd!=0. Idle or rd==0 -> o_con_RegWr=0 (addr/data hold).
// - Latency: ALU accept at N -> bank write enable at N+1 (bank updated at edge ending N+1).
//   Load enq at N -> earliest pop N+1 -> o_con_RegWr at N+2.
// - rd==0 from either source: accepted, consumes its slot, never asserts o_con_RegWr.
// - o_pending_mask: OR of onehot(rd) over valid FIFO entries | (o_con_RegWr ? onehot(o_addr_Rd)
//   : 0), bit 0 forced 0; combinational from registered state only.
// - Simultaneous enq+pop when not full: both occur, count unchanged. Full: no enq that cycle.
// - Ordering: writes to the same rd reach the bank in acceptance order (WAW block guarantees it).
// TESTING
// T1 reset: assert i_rst_n=0 with FIFO holding 3 entries -> count=0, all outputs 0, o_ld_ready=1.
// T2 ALU only: alu rd=5 data=32'hDEAD_BEEF at N -> o_con_RegWr=1, addr=5, data=DEADBEEF at N+1.
// T3 starvation: FIFO 1 entry (rd=7), ALU valid rd=9 every cycle -> ALU wins 3 cycles,
//    4th cycle o_alu_ready=0, load rd=7 written; starve_cnt back to 0.
// T4 WAW: FIFO holds rd=4; ALU rd=4 -> o_alu_ready=0 until load rd=4 written, then ALU rd=4
//    written next; bank final value = ALU data; mask bit4 set until last write leaves output.
// T5 full/wrap: 6 loads back-to-back with ALU continuously valid on rd=1, DEPTH=4 -> o_ld_ready
//    drops after 4 enq, forced drains free slots, all 6 written in order, ptrs wrap cleanly.
// T6 rd=0: ALU rd=0 and load rd=0 -> both accepted, o_con_RegWr stays 0, mask stays 0.

Source files
------------

// File: rtl/reg_writeback_arbiter_if.sv
// ----------------------------------------------------------------------------
// reg_writeback_arbiter_if
// Bundles the write-back arbiter's source handshakes, the register-bank write
// port and the pending-register mask into one interface.
//   master : producer side (ALU / load unit / bank model) - drives i_* signals
//   slave  : the arbiter itself - drives o_* signals
// Signals
//   i_alu_valid / o_alu_ready / i_alu_rd[4:0] / i_alu_data[31:0]  ALU result
//   i_ld_valid  / o_ld_ready  / i_ld_rd[4:0]  / i_ld_data[31:0]   load return
//   o_con_RegWr / o_addr_Rd[4:0] / o_data_Rd[31:0]               bank write port
//   o_pending_mask[31:0]                                          queued writes
// ----------------------------------------------------------------------------
interface reg_writeback_arbiter_if;
    logic        i_alu_valid;
    logic        o_alu_ready;
    logic [4:0]  i_alu_rd;
    logic [31:0] i_alu_data;
    logic        i_ld_valid;
    logic        o_ld_ready;
    logic [4:0]  i_ld_rd;
    logic [31:0] i_ld_data;
    logic        o_con_RegWr;
    logic [4:0]  o_addr_Rd;
    logic [31:0] o_data_Rd;
    logic [31:0] o_pending_mask;

    modport master (
        output i_alu_valid, i_alu_rd, i_alu_data,
        output i_ld_valid, i_ld_rd, i_ld_data,
        input  o_alu_ready, o_ld_ready,
        input  o_con_RegWr, o_addr_Rd, o_data_Rd, o_pending_mask
    );

    modport slave (
        input  i_alu_valid, i_alu_rd, i_alu_data,
        input  i_ld_valid, i_ld_rd, i_ld_data,
        output o_alu_ready, o_ld_ready,
        output o_con_RegWr, o_addr_Rd, o_data_Rd, o_pending_mask
    );
endinterface

// File: rtl/reg_writeback_arbiter.sv
// ----------------------------------------------------------------------------
// reg_writeback_arbiter
// Write-side front end of the register bank. Two write-back sources (ALU
// results and load returns) share the single bank write port. Load returns are
// buffered in a DEPTH-entry FIFO; the ALU normally wins, but a starvation
// counter forces a load drain after STARVE_MAX consecutive ALU wins, and an ALU
// write to a register that still has a queued load is held back so writes to
// the same register reach the bank in acceptance order.
// Ports
//   i_clk     rising-edge clock
//   i_rst_n   asynchronous active-low reset (flushes the FIFO, clears outputs)
//   wb        reg_writeback_arbiter_if.slave:
//               ALU handshake  i_alu_valid / o_alu_ready / i_alu_rd / i_alu_data
//               load handshake i_ld_valid  / o_ld_ready  / i_ld_rd  / i_ld_data
//               bank port      o_con_RegWr / o_addr_Rd / o_data_Rd (registered)
//               o_pending_mask registers with a write queued or in the output stage
// Parameters
//   DEPTH       load FIFO entries, power of two, >= 2
//   STARVE_MAX  consecutive ALU wins tolerated while loads wait, >= 1
// ----------------------------------------------------------------------------
module reg_writeback_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    reg_writeback_arbiter_if.slave wb
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [PW-1:0] PTR_ZERO    = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE     = PW'(1);
    localparam logic [SW-1:0] STARVE_LIM  = SW'(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_ZERO = {SW{1'b0}};
    localparam logic [SW-1:0] STARVE_ONE  = SW'(1);

    // One-hot decode of a 5-bit register index.
    function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
        rd_onehot = 32'h0000_0001 << rd;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [4:0]       fifo_rd_q   [DEPTH];
    logic [4:0]       fifo_rd_d   [DEPTH];
    logic [31:0]      fifo_data_q [DEPTH];
    logic [31:0]      fifo_data_d [DEPTH];
    logic [DEPTH-1:0] fifo_vld_q;
    logic [DEPTH-1:0] fifo_vld_d;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [SW-1:0]    starve_q;
    logic [SW-1:0]    starve_d;
    logic             con_q;
    logic             con_d;
    logic [4:0]       addr_q;
    logic [4:0]       addr_d;
    logic [31:0]      data_q;
    logic [31:0]      data_d;

    // ------------------------------------------------------------------------
    // Combinational decisions
    // ------------------------------------------------------------------------
    logic        fifo_ne_s;
    logic        fifo_full_s;
    logic        waw_hit_s;
    logic        waw_s;
    logic        force_s;
    logic        alu_ready_s;
    logic        alu_sel_s;
    logic        pop_s;
    logic        enq_s;
    logic [4:0]  head_rd_s;
    logic [31:0] head_data_s;
    logic [31:0] mask_s;

    // Arbitration: WAW and starvation gate the ALU; the FIFO head takes any slot the ALU leaves.
    always_comb begin
        waw_hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            waw_hit_s = waw_hit_s | (fifo_vld_q[i] & (fifo_rd_q[i] == wb.i_alu_rd));
        end
        fifo_ne_s   = (count_q != CNT_ZERO);
        fifo_full_s = (count_q == FULL_CNT);
        // rd 0 never writes the bank, so it can never create a WAW ordering problem.
        waw_s       = waw_hit_s & fifo_ne_s & (wb.i_alu_rd != 5'd0);
        force_s     = fifo_ne_s & (starve_q == STARVE_LIM);
        // Ready is independent of i_alu_valid so upstream can look at it freely.
        alu_ready_s = ~waw_s & ~force_s;
        alu_sel_s   = wb.i_alu_valid & alu_ready_s;
        pop_s       = ~alu_sel_s & fifo_ne_s;
        // Full blocks enqueue even if a pop happens the same cycle: keeps ready off the pop path.
        enq_s       = wb.i_ld_valid & ~fifo_full_s;
        head_rd_s   = fifo_rd_q[rd_ptr_q];
        head_data_s = fifo_data_q[rd_ptr_q];
    end

    // FIFO next state: pop frees the head slot, enqueue fills the tail slot.
    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        fifo_vld_d  = fifo_vld_q;
        // pop and enq cannot target the same slot: that needs an empty or a full FIFO.
        if (pop_s) begin
            fifo_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d             = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d             = rd_ptr_q;
        end
        if (enq_s) begin
            fifo_rd_d[wr_ptr_q]   = wb.i_ld_rd;
            fifo_data_d[wr_ptr_q] = wb.i_ld_data;
            fifo_vld_d[wr_ptr_q]  = 1'b1;
            wr_ptr_d              = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d              = wr_ptr_q;
        end
        case ({enq_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Starvation counter: counts ALU wins while loads wait, cleared by any pop or an empty FIFO.
    always_comb begin
        if (!fifo_ne_s || pop_s) begin
            starve_d = STARVE_ZERO;
        end else if (alu_sel_s && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + STARVE_ONE;
        end else begin
            starve_d = starve_q;
        end
    end

    // Output stage: capture the selected write; rd 0 is consumed without a bank write.
    always_comb begin
        if (alu_sel_s) begin
            con_d  = (wb.i_alu_rd != 5'd0);
            addr_d = wb.i_alu_rd;
            data_d = wb.i_alu_data;
        end else if (pop_s) begin
            con_d  = (head_rd_s != 5'd0);
            addr_d = head_rd_s;
            data_d = head_data_s;
        end else begin
            con_d  = 1'b0;
            addr_d = addr_q;
            data_d = data_q;
        end
    end

    // Pending mask: every queued destination plus the write currently presented to the bank.
    always_comb begin
        mask_s = 32'h0000_0000;
        for (int i = 0; i < DEPTH; i++) begin
            mask_s = mask_s | (fifo_vld_q[i] ? rd_onehot(fifo_rd_q[i]) : 32'h0000_0000);
        end
        mask_s    = mask_s | (con_q ? rd_onehot(addr_q) : 32'h0000_0000);
        mask_s[0] = 1'b0;
    end

    // State registers with asynchronous flush; queued loads are discarded on reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_rd_q[i]   <= 5'd0;
                fifo_data_q[i] <= 32'h0000_0000;
            end
            fifo_vld_q <= {DEPTH{1'b0}};
            wr_ptr_q   <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
            count_q    <= CNT_ZERO;
            starve_q   <= STARVE_ZERO;
            con_q      <= 1'b0;
            addr_q     <= 5'd0;
            data_q     <= 32'h0000_0000;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_rd_q[i]   <= fifo_rd_d[i];
                fifo_data_q[i] <= fifo_data_d[i];
            end
            fifo_vld_q <= fifo_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            con_q      <= con_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign wb.o_alu_ready    = alu_ready_s;
    assign wb.o_ld_ready     = ~fifo_full_s;
    assign wb.o_con_RegWr    = con_q;
    assign wb.o_addr_Rd      = addr_q;
    assign wb.o_data_Rd      = data_q;
    assign wb.o_pending_mask = mask_s;

endmodule
